// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
//   Shared constants and instruction-field helpers for the register
//   scoreboard: register count, pending-counter width, instruction field
//   positions and the register-writing opcode classifier.
package reg_scoreboard_pkg;

   localparam int NREG     = 16;
   localparam int ADDR_W   = 4;
   localparam int SB_CNT_W = 2;

   localparam int INSTR_W  = 24;
   localparam int OPC_HI   = 23;
   localparam int OPC_LO   = 16;
   localparam int DEST_HI  = 15;
   localparam int DEST_LO  = 12;

   // Opcodes in class 2'b11 (stores, branches, system ops) leave the
   // register file untouched; every other opcode writes its destination.
   function automatic logic reg_write_fn(input logic [7:0] opc);
      return (opc[7:6] != 2'b11);
   endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter
//   Pending-write counter for one register.
//   clk, rst : pipeline clock, synchronous active-high reset
//   clr      : flush, clears the count (rst wins, same effect)
//   inc, dec : accepted issue / accepted writeback to this register
//   cnt      : current pending count
//   nonzero  : cnt != 0 (busy)
//   full     : cnt == maximum, no further issue allowed
import reg_scoreboard_pkg::*;

module sb_counter #(
   parameter int CNT_W = SB_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             nonzero,
   output logic             full
);

   localparam logic [CNT_W-1:0] MAXCNT = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && !dec && !full) begin
         cnt <= cnt + ONE;
      end else if (dec && !inc && nonzero) begin
         cnt <= cnt - ONE;
      end
   end

   assign nonzero = (cnt != '0);
   assign full    = (cnt == MAXCNT);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Tracks in-flight register writes between decode issue and writeback.
//   clk, rst      : pipeline clock, synchronous active-high reset
//   id_src_gp     : decode source register
//   id_tgt_gp     : decode second source register
//   issue_valid   : decode instruction leaves ID this cycle
//   issue_instr   : issuing instruction (opcode [23:16], dest [15:12])
//   wb_valid      : register-file write this cycle
//   wb_addr       : register written
//   flush         : cancel all in-flight writes
//   busy          : per-register pending-write flag (registered)
//   stall         : decode stall (combinational)
//   err_underflow : sticky, writeback to a register with nothing pending
//   err_issue     : sticky, issue attempted while stalled
import reg_scoreboard_pkg::*;

module reg_scoreboard (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  id_src_gp,
   input  logic [ADDR_W-1:0]  id_tgt_gp,
   input  logic               issue_valid,
   input  logic [INSTR_W-1:0] issue_instr,
   input  logic               wb_valid,
   input  logic [ADDR_W-1:0]  wb_addr,
   input  logic               flush,
   output logic [NREG-1:0]    busy,
   output logic               stall,
   output logic               err_underflow,
   output logic               err_issue
);

   logic [NREG-1:0]   full_vec;
   logic [NREG-1:0]   inc_vec;
   logic [NREG-1:0]   dec_vec;
   logic [ADDR_W-1:0] dest;
   logic              writes;
   logic              dest_full;
   logic              issue_accept;
   logic              wb_accept;
   logic              wb_underflow;

   assign writes       = reg_write_fn(issue_instr[OPC_HI:OPC_LO]);
   assign dest         = issue_instr[DEST_HI:DEST_LO];
   assign dest_full    = writes && full_vec[dest];
   assign stall        = busy[id_src_gp] || busy[id_tgt_gp] || dest_full;

   assign issue_accept = issue_valid && writes && !stall && !flush;
   assign wb_accept    = wb_valid && busy[wb_addr] && !flush;
   assign wb_underflow = wb_valid && !busy[wb_addr];

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (issue_accept) inc_vec[dest]    = 1'b1;
      if (wb_accept)    dec_vec[wb_addr] = 1'b1;
   end

   for (genvar r = 0; r < NREG; r++) begin : g_cnt
      logic [SB_CNT_W-1:0] cnt_unused;
      sb_counter #(.CNT_W(SB_CNT_W)) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .clr     (flush),
         .inc     (inc_vec[r]),
         .dec     (dec_vec[r]),
         .cnt     (cnt_unused),
         .nonzero (busy[r]),
         .full    (full_vec[r])
      );
   end

   // Error checks are masked during flush; flags survive flush, not rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_underflow <= 1'b0;
         err_issue     <= 1'b0;
      end else if (!flush) begin
         if (wb_underflow)         err_underflow <= 1'b1;
         if (issue_valid && stall) err_issue     <= 1'b1;
      end
   end

endmodule
